alarm_qsys_onchip_mem_arbiter: RTL
==================================

# alarm_qsys_onchip_mem_arbiter

Two-master arbiter that shares the single-port 1024×32 on-chip RAM between two Avalon-MM requesters, e.g. the CPU data master and the alarm/time-keeping DMA. It sits between the masters and the RAM slave port. It issues at most one transfer per cycle, routes one-cycle-latency read data back to the owning master, and keeps saturating per-master grant counters for debug.

## Interface
Parameters:
- ADDR_W, 10, word address width (matches 1024-word RAM)
- DATA_W, 32, data width; byteenable width is DATA_W/8
- CNT_W, 16, grant counter width

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- m0_address, m1_address  in  ADDR_W  word address
- m0_byteenable, m1_byteenable  in  DATA_W/8  byte lanes (write only)
- m0_read, m1_read  in  1  read request
- m0_write, m1_write  in  1  write request
- m0_writedata, m1_writedata  in  DATA_W  write data
- m0_waitrequest, m1_waitrequest  out  1  high = command not accepted this cycle
- m0_readdata, m1_readdata  out  DATA_W  read data
- m0_readdatavalid, m1_readdatavalid  out  1  read data valid strobe
- mem_address  out  ADDR_W  to RAM
- mem_byteenable  out  DATA_W/8  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_writedata  out  DATA_W  to RAM
- mem_clken  out  1  RAM clock enable
- mem_readdata  in  DATA_W  RAM q output (address registered in RAM, data unregistered)
- grant_cnt0, grant_cnt1  out  CNT_W  accepted commands per master, saturating

## Operation
- Request: mX_req = mX_read | mX_write. Read and write together from one master is treated as a write. The read is dropped, and no readdatavalid is produced for it.
- Arbitration is combinational within the cycle. Only one master requesting: it wins. Both requesting: round-robin against register last_grant, and the master not granted last wins.
- last_grant updates only on a grant. Reset value 1, so m0 wins the first tie.
- Winner: mX_waitrequest=0. Loser or idle master: waitrequest=1. A master must hold its command stable while waitrequest=1.
- Memory mux: mem_* carry the winner's address, byteenable and writedata.
  - mem_chipselect=1 when any grant is made.
  - mem_write = winner's write.
  - No grant: mem_chipselect=0, mem_write=0, and address/data hold their last values.
- mem_clken is tied to 1 outside reset and is 0 while reset is high.
- Read-return pipeline: registers rd_pend (1 bit) and rd_owner (1 bit) are set on a granted read and cleared otherwise.
  - Next cycle: m{rd_owner}_readdatavalid = rd_pend.
  - Both mX_readdata are driven from mem_readdata, with no registering.
- Ordering: every command completes in grant order. A read following a write to the same address returns the new data.
- Counters: grant_cntX increments on each accepted command of master X and saturates at 2^CNT_W−1.
- Reset: all registers are cleared and last_grant=1. While reset is high, both waitrequest=1 and no grants are made.
  - A read granted in the cycle before reset asserts produces no readdatavalid.

## Timing
- Reset values:
  - waitrequest=1
  - readdatavalid=0
  - mem_chipselect=0, mem_write=0, mem_clken=0
  - mem_address=0, mem_byteenable=0, mem_writedata=0
  - grant_cnt=0
- Grant latency: 0 cycles when the memory is idle. Command accepted in cycle N, present on mem_* in cycle N.
- Read latency: readdatavalid and readdata are valid in cycle N+1.
- Throughput: one command per cycle, and back-to-back reads are fully pipelined.
- Fairness: two continuously requesting masters alternate every cycle. Worst-case wait is 1 cycle.
- Write occupies one cycle and returns no response.

## Configuration
- ALARM_MEM_ARB_FIXED_PRIO_EN defined:
  - Fixed priority, m0 always wins ties.
  - last_grant logic is removed.
  - m1 may starve.
- Undefined (default): round-robin as above.

## Test plan
- Reset, then m0 writes 0xDEADBEEF to addr 0x005 with byteenable 0xF, then reads 0x005 → readdatavalid on m0 one cycle after grant with 0xDEADBEEF, and m1_readdatavalid stays 0.
- Both masters read every cycle (m0 at 0x010, m1 at 0x020, preloaded with 0x11111111 and 0x22222222) → grants alternate m0,m1,m0,…, each readdatavalid arrives one cycle after its grant with the correct data, and grant_cnt0 and grant_cnt1 differ by at most 1.
- m0 writes 0xAABBCCDD with byteenable 0x3 to addr 0x3FF (previously 0x00000000), then m1 reads 0x3FF → m1 gets 0x0000CCDD.
- Assert reset the cycle after an m1 read is granted → no m1_readdatavalid, and all outputs take their reset values the next cycle.
- Force grant_cnt0 near saturation by issuing 2^CNT_W+3 m0 commands (CNT_W=4 build) → grant_cnt0 stops at 15.
- With ALARM_MEM_ARB_FIXED_PRIO_EN defined, both masters requesting continuously → m0 granted every cycle and m1_waitrequest stays 1.

Source files
------------

// File: rtl/alarm_qsys_onchip_mem_arbiter.sv
// Two-master arbiter sharing the single-port on-chip RAM, with read-return routing and grant counters.
// Build option: define ALARM_MEM_ARB_FIXED_PRIO_EN for fixed m0-first priority instead of round-robin.
module alarm_qsys_onchip_mem_arbiter #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic [CNT_W-1:0]      grant_cnt0,
    output logic [CNT_W-1:0]      grant_cnt1
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              m0_req, m1_req;
    logic              gnt0, gnt1, any_gnt;
    logic              win_read, win_write;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_owner_q, rd_owner_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    assign m0_req = m0_read | m0_write;
    assign m1_req = m1_read | m1_write;

`ifdef ALARM_MEM_ARB_FIXED_PRIO_EN
    // m0 always wins a tie; m1 only gets the RAM when m0 is idle.
    always_comb begin
        gnt0 = ~reset & m0_req;
        gnt1 = ~reset & m1_req & ~m0_req;
    end
`else
    logic last_grant_q, last_grant_d;

    // On a tie the master not granted last time wins.
    always_comb begin
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        last_grant_d = last_grant_q;
        if (!reset) begin
            if (m0_req && m1_req) begin
                gnt0 = last_grant_q;
                gnt1 = ~last_grant_q;
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
        if (gnt0) begin
            last_grant_d = 1'b0;
        end else if (gnt1) begin
            last_grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign any_gnt   = gnt0 | gnt1;
    assign win_read  = gnt1 ? m1_read  : m0_read;
    assign win_write = gnt1 ? m1_write : m0_write;

    // Winner mux; without a grant the RAM command lines hold their last value.
    always_comb begin
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        if (gnt1) begin
            addr_d  = m1_address;
            be_d    = m1_byteenable;
            wdata_d = m1_writedata;
        end else if (gnt0) begin
            addr_d  = m0_address;
            be_d    = m0_byteenable;
            wdata_d = m0_writedata;
        end
        // A combined read+write is a write: no read return is scheduled.
        rd_pend_d  = any_gnt & win_read & ~win_write;
        rd_owner_d = gnt1;
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (gnt0 && (cnt0_q != {CNT_W{1'b1}})) begin
            cnt0_d = cnt0_q + CNT_W'(1);
        end
        if (gnt1 && (cnt1_q != {CNT_W{1'b1}})) begin
            cnt1_d = cnt1_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

    assign m0_waitrequest = ~gnt0;
    assign m1_waitrequest = ~gnt1;
    assign mem_address    = addr_d;
    assign mem_byteenable = be_d;
    assign mem_writedata  = wdata_d;
    assign mem_chipselect = any_gnt;
    assign mem_write      = any_gnt & win_write;
    assign mem_clken      = ~reset;

    // Read return is suppressed while reset is high so a read granted just before reset never completes.
    assign m0_readdatavalid = rd_pend_q & ~rd_owner_q & ~reset;
    assign m1_readdatavalid = rd_pend_q &  rd_owner_q & ~reset;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign grant_cnt0       = cnt0_q;
    assign grant_cnt1       = cnt1_q;

endmodule
